// File: rtl/exu_div_seq_pkg.sv
// Shared definitions for the RV64 divide sequencer: ALU op encodings, FSM states
// and small op-decode helpers.
package exu_div_seq_pkg;

   localparam int ALUOP_WIDTH = 5;

   // Divide ops share op[4:3]=2'b01; op[2]=W, op[1]=remainder, op[0]=unsigned.
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_DIV   = 5'b01000;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_DIVU  = 5'b01001;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_REM   = 5'b01010;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_REMU  = 5'b01011;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_DIVW  = 5'b01100;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_DIVUW = 5'b01101;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_REMW  = 5'b01110;
   localparam logic [ALUOP_WIDTH-1:0] ALU_OP_REMUW = 5'b01111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_CALC  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } div_state_e;

   function automatic logic op_is_div(input logic [ALUOP_WIDTH-1:0] op);
      return op[4:3] == 2'b01;
   endfunction

   function automatic logic op_is_w(input logic [ALUOP_WIDTH-1:0] op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input logic [ALUOP_WIDTH-1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_unsigned(input logic [ALUOP_WIDTH-1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/exu_div_seq_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract divisor if it fits.
module exu_div_seq_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] dvsr,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   logic [XLEN:0] r_sh;
   logic [XLEN:0] r_sub;
   logic          fits;

   // r_sh < 2*dvsr, so the top bit of the difference is a clean borrow flag.
   assign r_sh    = {rem, quo[XLEN-1]};
   assign r_sub   = r_sh - {1'b0, dvsr};
   assign fits    = ~r_sub[XLEN];
   assign rem_nxt = fits ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/exu_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU (+W) sequencer. Valid/ready on both sides: a transfer
// happens in a cycle where valid and ready are both high; flush aborts without a result.
module exu_div_seq
   import exu_div_seq_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                   ds_clk_i,
   input  logic                   ds_rst_i,
   input  logic                   ds_valid_i,
   output logic                   ds_ready_o,
   input  logic [ALUOP_WIDTH-1:0] ds_aluop_i,
   input  logic [XLEN-1:0]        ds_rs1_i,
   input  logic [XLEN-1:0]        ds_rs2_i,
   input  logic                   ds_flush_i,
   output logic                   ds_valid_o,
   input  logic                   ds_ready_i,
   output logic [XLEN-1:0]        ds_result_o,
   output logic                   ds_stall_o,
   output div_state_e             ds_state_o
);

   localparam int CW = $clog2(XLEN) + 1;

   div_state_e      state;
   logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvsr_q, result_q;
   logic [CW-1:0]   cnt_q;
   logic            w_q, rem_sel_q, uns_q, neg_q_q, neg_r_q, valid_q;
   logic            accept;

   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, spec_res;
   logic            a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin, fix_res;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
      return {{(XLEN-32){x[31]}}, x[31:0]};
   endfunction

   function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
      return w ? sext32(x) : x;
   endfunction

   assign ds_ready_o  = (state == ST_IDLE);
   assign ds_stall_o  = (state != ST_IDLE);
   assign ds_valid_o  = valid_q & ~ds_flush_i;
   assign ds_result_o = result_q;
   assign ds_state_o  = state;
   assign accept      = ds_valid_i & ds_ready_o & ~ds_flush_i & op_is_div(ds_aluop_i);

   // Operand conditioning and special-case detection, evaluated in PREP.
   always_comb begin
      a_ext = a_q;
      b_ext = b_q;
      if (w_q) begin
         a_ext = uns_q ? {{(XLEN-32){1'b0}}, a_q[31:0]} : sext32(a_q);
         b_ext = uns_q ? {{(XLEN-32){1'b0}}, b_q[31:0]} : sext32(b_q);
      end
      a_neg   = ~uns_q & a_ext[XLEN-1];
      b_neg   = ~uns_q & b_ext[XLEN-1];
      a_abs   = a_neg ? -a_ext : a_ext;
      b_abs   = b_neg ? -b_ext : b_ext;
      min_val = w_q ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (b_ext == '0);
      ovf      = ~uns_q & (a_ext == min_val) & (b_ext == '1);
      spec_res = '0;
      if (div_zero)
         spec_res = rem_sel_q ? a_ext : '1;
      else if (ovf)
         spec_res = rem_sel_q ? '0 : min_val;
   end

   exu_div_seq_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .dvsr    (dvsr_q),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   assign q_fin   = neg_q_q ? -quo_q : quo_q;
   assign r_fin   = neg_r_q ? -rem_q : rem_q;
   assign fix_res = rem_sel_q ? r_fin : q_fin;

   always_ff @(posedge ds_clk_i or posedge ds_rst_i) begin
      if (ds_rst_i) begin
         state     <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         w_q       <= 1'b0;
         rem_sel_q <= 1'b0;
         uns_q     <= 1'b0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (ds_flush_i && state != ST_IDLE) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q       <= ds_rs1_i;
                  b_q       <= ds_rs2_i;
                  w_q       <= op_is_w(ds_aluop_i);
                  rem_sel_q <= op_is_rem(ds_aluop_i);
                  uns_q     <= op_is_unsigned(ds_aluop_i);
                  state     <= ST_PREP;
               end
            end
            ST_PREP: begin
               if (div_zero || ovf) begin
                  result_q <= wfix(w_q, spec_res);
                  valid_q  <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  // W dividends sit in the upper half so 32 shifts consume them.
                  rem_q   <= '0;
                  quo_q   <= w_q ? (a_abs << 32) : a_abs;
                  dvsr_q  <= b_abs;
                  neg_q_q <= a_neg ^ b_neg;
                  neg_r_q <= a_neg;
                  cnt_q   <= w_q ? CW'(32) : CW'(XLEN);
                  state   <= ST_CALC;
               end
            end
            ST_CALC: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1))
                  state <= ST_FIXUP;
            end
            ST_FIXUP: begin
               result_q <= wfix(w_q, fix_res);
               valid_q  <= 1'b1;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (ds_ready_i) begin
                  valid_q <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exu_div_seq.sv
// Directed bench for exu_div_seq: hand-computed results and latencies, backpressure,
// flush and asynchronous reset.
module tb_exu_div_seq;
   import exu_div_seq_pkg::*;

   logic                   clk, rst;
   logic                   valid_i, ready_o, flush, valid_o, ready_i, stall;
   logic [ALUOP_WIDTH-1:0] aluop;
   logic [63:0]            rs1, rs2, result;
   div_state_e             state;

   int vectors    = 0;
   int miscompares = 0;

   exu_div_seq #(.XLEN(64)) dut (
      .ds_clk_i    (clk),
      .ds_rst_i    (rst),
      .ds_valid_i  (valid_i),
      .ds_ready_o  (ready_o),
      .ds_aluop_i  (aluop),
      .ds_rs1_i    (rs1),
      .ds_rs2_i    (rs2),
      .ds_flush_i  (flush),
      .ds_valid_o  (valid_o),
      .ds_ready_i  (ready_i),
      .ds_result_o (result),
      .ds_stall_o  (stall),
      .ds_state_o  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after a posedge with the DUT idle; returns #1 after the posedge that
   // follows the cycle in which valid_o was seen.
   task automatic do_op(input string tag, input logic [ALUOP_WIDTH-1:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
      int k;
      valid_i = 1'b1; aluop = op; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      valid_i = 1'b0;
      k = 1;
      while (k < 200) begin
         @(negedge clk);
         if (valid_o === 1'b1) break;
         @(posedge clk); #1;
         k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'(lat));
      chk({tag, "_res"}, result, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      logic bad;
      logic seen;
      logic [63:0] held;
      rst = 1'b1; valid_i = 1'b0; flush = 1'b0; ready_i = 1'b1;
      aluop = '0; rs1 = '0; rs2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_state", 64'(state), 64'(ST_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("divu_100_7", ALU_OP_DIVU, 64'd100, 64'd7, 64'd14, 67);
      do_op("remu_100_7", ALU_OP_REMU, 64'd100, 64'd7, 64'd2, 67);
      do_op("div_m7_2", ALU_OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
      do_op("rem_m7_2", ALU_OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
      do_op("divw_m7_2", ALU_OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35);
      do_op("divuw_big", ALU_OP_DIVUW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 35);
      do_op("remuw_big", ALU_OP_REMUW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'd1, 35);
      do_op("divu_max_3", ALU_OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 67);
      do_op("remu_max_hi", ALU_OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
            64'h7FFF_FFFF_FFFF_FFFE, 67);
      do_op("div_5_0", ALU_OP_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
      do_op("remu_5_0", ALU_OP_REMU, 64'd5, 64'd0, 64'd5, 2);
      do_op("div_ovf", ALU_OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 2);
      do_op("rem_ovf", ALU_OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
      do_op("divw_ovf", ALU_OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 2);

      // Backpressure: result held with ready_i low for 10 cycles.
      ready_i = 1'b0;
      do_op("hold", ALU_OP_DIVU, 64'd100, 64'd7, 64'd14, 67);
      bad = 1'b0;
      held = result;
      repeat (10) begin
         @(negedge clk);
         if (valid_o !== 1'b1 || stall !== 1'b1 || ready_o !== 1'b0 || result !== 64'd14)
            bad = 1'b1;
         @(posedge clk); #1;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      chk("hold_value", held, 64'd14);
      ready_i = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_ready", 64'(ready_o), 64'd1);
      chk("hold_release_stall", 64'(stall), 64'd0);
      chk("hold_release_valid", 64'(valid_o), 64'd0);

      // Non-divide op is ignored.
      valid_i = 1'b1; aluop = 5'b00011; rs1 = 64'd9; rs2 = 64'd3;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("nondiv_stall", 64'(stall), 64'd0);
      chk("nondiv_ready", 64'(ready_o), 64'd1);

      // Flush in IDLE blocks acceptance.
      valid_i = 1'b1; flush = 1'b1; aluop = ALU_OP_DIVU;
      @(posedge clk); #1;
      valid_i = 1'b0; flush = 1'b0;
      chk("idle_flush_stall", 64'(stall), 64'd0);

      // Flush at CALC cycle 20 (cycle 21 after accept).
      valid_i = 1'b1; aluop = ALU_OP_DIVU; rs1 = 64'd100; rs2 = 64'd7;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("flush_in_calc", 64'(state), 64'(ST_CALC));
      flush = 1'b1;
      @(negedge clk);
      chk("flush_valid_same", 64'(valid_o), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready_next", 64'(ready_o), 64'd1);
      chk("flush_stall_next", 64'(stall), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (valid_o === 1'b1) seen = 1'b1;
      end
      chk("flush_no_result", 64'(seen), 64'd0);
      @(posedge clk); #1;

      // Async reset at cycle 30 of a 64-bit divide.
      valid_i = 1'b1; aluop = ALU_OP_DIV; rs1 = 64'd1000; rs2 = 64'd3;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (29) @(posedge clk);
      #3;
      chk("pre_rst_stall", 64'(stall), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_ready", 64'(ready_o), 64'd1);
      chk("arst_valid", 64'(valid_o), 64'd0);
      chk("arst_stall", 64'(stall), 64'd0);
      chk("arst_result", result, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (valid_o === 1'b1) seen = 1'b1;
      end
      chk("arst_no_result", 64'(seen), 64'd0);
      @(posedge clk); #1;

      do_op("remw_after_rst", ALU_OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 35);
      chk("final_idle", 64'(ready_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
